// File: rtl/rank_order_sorter.sv
// rank_order_sorter: holds one image and emits pixel indices brightest-first, ties in ascending index order.
// Latency: one pixel compared per SCAN cycle; a hit shows on FOUND_NEXT_INDEX/NEXT_INDEX the cycle after it is found.
// Backpressure: after each hit the scan stalls until AERIN_CTRL_BUSY has risen and then fallen again.
module rank_order_sorter #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int MIN_VALUE       = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IMG_WE,
  input  logic [IMAGE_SIZE_BITS-1:0] IMG_ADDR,
  input  logic [PIXEL_BITS-1:0]      IMG_DATA,
  input  logic                       START,
  input  logic                       AERIN_CTRL_BUSY,
  output logic [9:0]                 NEXT_INDEX,
  output logic                       FOUND_NEXT_INDEX,
  output logic                       SORT_BUSY,
  output logic                       SORT_DONE
);

  // Scan bounds, sized to the registers they are compared against.
  localparam logic [IMAGE_SIZE_BITS-1:0] ADDR_LAST = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0]      VAL_MAX   = PIXEL_BITS'(PIXEL_MAX_VALUE);
  localparam logic [PIXEL_BITS-1:0]      VAL_MIN   = PIXEL_BITS'(MIN_VALUE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_REL = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                     state, state_nxt;
  logic [IMAGE_SIZE_BITS-1:0] addr, addr_nxt;
  logic [PIXEL_BITS-1:0]      val, val_nxt;
  logic [9:0]                 next_index, next_index_nxt;
  logic                       found, found_nxt;

  // Image store; deliberately not reset so an image survives an aborted pass.
  logic [PIXEL_BITS-1:0]      mem [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0]      pixel;

  // Scan-pointer advance: next address, next intensity, or end of pass.
  logic [IMAGE_SIZE_BITS-1:0] adv_addr;
  logic [PIXEL_BITS-1:0]      adv_val;
  logic                       adv_last;

  // Image writes are accepted only while idle so a running pass sees a stable image.
  always_ff @(posedge CLK) begin
    if (IMG_WE && (state == IDLE)) begin
      mem[IMG_ADDR] <= IMG_DATA;
    end
  end

  assign pixel = mem[addr];

  // Advance logic; the last-value check precedes the decrement so val never wraps when MIN_VALUE is 0.
  always_comb begin
    adv_addr = addr;
    adv_val  = val;
    adv_last = 1'b0;
    if (addr < ADDR_LAST) begin
      adv_addr = addr + IMAGE_SIZE_BITS'(1);
    end else if (val > VAL_MIN) begin
      adv_addr = '0;
      adv_val  = val - PIXEL_BITS'(1);
    end else begin
      adv_last = 1'b1;
    end
  end

  // State, scan pointer and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      val        <= '0;
      next_index <= '0;
      found      <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      val        <= val_nxt;
      next_index <= next_index_nxt;
      found      <= found_nxt;
    end
  end

  // Next-state logic: scan, hand one index to the AER controller, wait for its full busy cycle.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    val_nxt        = val;
    next_index_nxt = next_index;
    found_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          addr_nxt  = '0;
          val_nxt   = VAL_MAX;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (pixel == val) begin
          // addr is held here; it moves on only once the transfer completes.
          next_index_nxt = 10'(addr);
          found_nxt      = 1'b1;
          state_nxt      = WAIT_ACK;
        end else begin
          addr_nxt  = adv_addr;
          val_nxt   = adv_val;
          state_nxt = adv_last ? DONE : SCAN;
        end
      end
      WAIT_ACK: begin
        // Busy already high on entry is taken as the controller having accepted the index.
        if (AERIN_CTRL_BUSY) begin
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!AERIN_CTRL_BUSY) begin
          addr_nxt  = adv_addr;
          val_nxt   = adv_val;
          state_nxt = adv_last ? DONE : SCAN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign NEXT_INDEX       = next_index;
  assign FOUND_NEXT_INDEX = found;
  assign SORT_BUSY        = (state != IDLE);
  assign SORT_DONE        = (state == DONE);

endmodule

// File: tb/tb_rank_order_sorter.sv
// Directed bench for rank_order_sorter with a 16-pixel image and 8-bit pixels.
// A cycle-level AER responder model answers every FOUND pulse.
// Expected emission orders and cycle counts are hand-derived per vector.
module tb_rank_order_sorter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IMG_WE;
  logic [3:0] IMG_ADDR;
  logic [7:0] IMG_DATA;
  logic       START;
  logic       AERIN_CTRL_BUSY;
  logic [9:0] NEXT_INDEX;
  logic       FOUND_NEXT_INDEX;
  logic       SORT_BUSY;
  logic       SORT_DONE;

  int checks   = 0;
  int failures = 0;

  logic [9:0] got_q [$];
  int         done_cnt;

  typedef struct {
    string            name;
    logic [15:0][7:0] img;
    int               n_exp;
    logic [15:0][9:0] exp_idx;
    int               rise;
    int               hold;
    int               exp_busy;   // -1: cycle count not checked
  } vec_t;

  vec_t vecs [6];

  rank_order_sorter #(
    .IMAGE_SIZE(16),
    .IMAGE_SIZE_BITS(4),
    .PIXEL_MAX_VALUE(255),
    .PIXEL_BITS(8),
    .MIN_VALUE(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .IMG_WE(IMG_WE),
    .IMG_ADDR(IMG_ADDR),
    .IMG_DATA(IMG_DATA),
    .START(START),
    .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY),
    .NEXT_INDEX(NEXT_INDEX),
    .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
    .SORT_BUSY(SORT_BUSY),
    .SORT_DONE(SORT_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_image(input logic [15:0][7:0] img);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      IMG_WE   = 1'b1;
      IMG_ADDR = 4'(i);
      IMG_DATA = img[i];
    end
    @(negedge CLK);
    IMG_WE = 1'b0;
  endtask

  // Starts a pass and plays the AER controller until SORT_DONE or the budget runs out.
  task automatic run_pass(input int rise_dly, input int hold, input bit inject,
                          input int budget, output int busy_cycles);
    int phase, cnt, cyc, drop_cyc;
    bit prev_found, finished, injected;
    got_q.delete();
    done_cnt   = 0;
    phase      = 0;
    cnt        = 0;
    cyc        = 0;
    drop_cyc   = -100;
    prev_found = 1'b0;
    finished   = 1'b0;
    injected   = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk_eq("busy_after_start", int'(SORT_BUSY), 1);
    busy_cycles = 1;
    while (!finished && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (SORT_BUSY) busy_cycles++;
      if (prev_found) begin
        chk_eq("found_width", int'(FOUND_NEXT_INDEX), 0);
      end else if (FOUND_NEXT_INDEX) begin
        chk_eq("found_while_pending", phase, 0);
        chk_ok("gap_after_release", (cyc - drop_cyc) >= 2, cyc - drop_cyc, 2);
        got_q.push_back(NEXT_INDEX);
        phase = 1;
        cnt   = 0;
      end
      prev_found = FOUND_NEXT_INDEX;
      if (SORT_DONE) begin
        done_cnt++;
        finished = 1'b1;
      end
      if (phase == 1) begin
        cnt++;
        if (cnt >= rise_dly) begin
          AERIN_CTRL_BUSY = 1'b1;
          phase = 2;
          cnt   = 0;
        end
      end else if (phase == 2) begin
        cnt++;
        if (inject && !injected && cnt == 1) begin
          START    = 1'b1;
          IMG_WE   = 1'b1;
          IMG_ADDR = 4'd0;
          IMG_DATA = 8'd255;
          injected = 1'b1;
        end else if (cnt == 2) begin
          START  = 1'b0;
          IMG_WE = 1'b0;
        end
        if (cnt >= hold) begin
          AERIN_CTRL_BUSY = 1'b0;
          drop_cyc = cyc;
          phase    = 0;
        end
      end
    end
    if (!finished) begin
      chk_ok("pass_timeout", 1'b0, cyc, budget);
    end else begin
      @(negedge CLK);
      chk_eq("done_width", int'(SORT_DONE), 0);
      chk_eq("busy_after_done", int'(SORT_BUSY), 0);
    end
  endtask

  task automatic compare_seq(input string name, input int n_exp, input logic [15:0][9:0] exp_idx);
    int n;
    chk_eq({name, "_count"}, got_q.size(), n_exp);
    n = (got_q.size() < n_exp) ? got_q.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      chk_eq({name, "_index"}, int'(got_q[i]), int'(exp_idx[i]));
    end
    chk_eq({name, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    logic [15:0][7:0] basic_img;
    logic [15:0][9:0] basic_exp;
    int bc;
    int waited;

    basic_img    = '0;
    basic_img[5] = 8'd255;
    basic_img[3] = 8'd200;
    basic_img[7] = 8'd200;
    basic_exp    = '0;
    basic_exp[0] = 10'd5;
    basic_exp[1] = 10'd3;
    basic_exp[2] = 10'd7;

    vecs[0] = '{name: "basic", img: basic_img, n_exp: 3, exp_idx: basic_exp,
                rise: 2, hold: 4, exp_busy: -1};
    vecs[1] = '{name: "backpressure", img: basic_img, n_exp: 3, exp_idx: basic_exp,
                rise: 2, hold: 50, exp_busy: -1};
    vecs[2] = '{name: "uniform", img: '1, n_exp: 16, exp_idx: '0,
                rise: 1, hold: 2, exp_busy: -1};
    for (int i = 0; i < 16; i++) vecs[2].exp_idx[i] = 10'(i);
    vecs[3] = '{name: "min_edge", img: '0, n_exp: 2, exp_idx: '0,
                rise: 3, hold: 3, exp_busy: -1};
    vecs[3].img[9]     = 8'd1;
    vecs[3].img[2]     = 8'd2;
    vecs[3].exp_idx[0] = 10'd2;
    vecs[3].exp_idx[1] = 10'd9;
    vecs[4] = '{name: "ties", img: '0, n_exp: 5, exp_idx: '0,
                rise: 1, hold: 1, exp_busy: -1};
    vecs[4].img[15]    = 8'd255;
    vecs[4].img[12]    = 8'd254;
    vecs[4].img[8]     = 8'd128;
    vecs[4].img[4]     = 8'd128;
    vecs[4].img[0]     = 8'd1;
    vecs[4].exp_idx[0] = 10'd15;
    vecs[4].exp_idx[1] = 10'd12;
    vecs[4].exp_idx[2] = 10'd4;
    vecs[4].exp_idx[3] = 10'd8;
    vecs[4].exp_idx[4] = 10'd0;
    // 255 intensities x 16 pixels of SCAN plus one DONE cycle.
    vecs[5] = '{name: "empty", img: '0, n_exp: 0, exp_idx: '0,
                rise: 1, hold: 1, exp_busy: 4081};

    // Reset held with START asserted.
    RST = 1'b1;
    START = 1'b1;
    IMG_WE = 1'b0;
    IMG_ADDR = '0;
    IMG_DATA = '0;
    AERIN_CTRL_BUSY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_eq("reset_outputs", int'({NEXT_INDEX, FOUND_NEXT_INDEX, SORT_BUSY, SORT_DONE}), 0);
    end
    RST = 1'b0;
    START = 1'b0;

    // Table-driven passes.
    foreach (vecs[v]) begin
      load_image(vecs[v].img);
      run_pass(vecs[v].rise, vecs[v].hold, 1'b0, 6000, bc);
      compare_seq(vecs[v].name, vecs[v].n_exp, vecs[v].exp_idx);
      if (vecs[v].exp_busy >= 0) chk_eq({vecs[v].name, "_busy_cycles"}, bc, vecs[v].exp_busy);
    end

    // START and an image write issued while waiting for busy to fall are ignored.
    load_image(basic_img);
    run_pass(2, 4, 1'b1, 6000, bc);
    compare_seq("ignored_inputs", 3, basic_exp);
    run_pass(2, 4, 1'b0, 6000, bc);
    compare_seq("readback", 3, basic_exp);

    // Reset while in WAIT_ACK abandons the pass but keeps the image.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    waited = 0;
    while (!FOUND_NEXT_INDEX && waited < 6000) begin
      @(negedge CLK);
      waited++;
    end
    chk_ok("mid_found_seen", FOUND_NEXT_INDEX == 1'b1, waited, 6000);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_eq("mid_reset_found", int'(FOUND_NEXT_INDEX), 0);
    chk_eq("mid_reset_busy", int'(SORT_BUSY), 0);
    chk_eq("mid_reset_index", int'(NEXT_INDEX), 0);
    run_pass(2, 4, 1'b0, 6000, bc);
    compare_seq("after_reset", 3, basic_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
